uart_tx_mmio: RTL

- Memory-mapped UART transmitter (8N1) on the core data bus, alongside the mtime, LED and USB control registers.
- Consumes the already-shifted bus signals that top produces: address, write value and byte write sections.
- Returns a registered read value and select flag, which top merges into its memory-mapped register read mux.
- Drives one gpio pin as the serial TX line; buffers outgoing bytes in a small FIFO so firmware does not stall per byte.

---
 rtl/uart_tx_mmio.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Register map (word offsets from BASE_ADDRESS):
//   +0 DATA    W: lane0 pushes a byte into the FIFO.     R: 0
//   +4 STATUS  R: [0] full [1] empty [2] busy [3] overflow (sticky)
//                 [4] irq_enable [15:8] FIFO count
//              W (lane0): bit3=1 clears overflow, bit4 -> irq_enable
//   +8 DIVISOR R/W: 16-bit clk24 cycles per bit (lanes 0/1), 0 acts as 1
//
// Ports:
//   clk24                  core clock, rising edge
//   reset                  synchronous, active high
//   memory_address         byte address of the current bus access
//   memory_write_value     lane-shifted write data
//   memory_write_sections  byte-lane write enables (0 = no write)
//   read_value             registered read data for last cycle's address
//   read_selected          registered: last cycle's address hit this block
//   tx                     serial output, idle high
//   irq                    level interrupt: enabled, FIFO empty and idle
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDRESS    = 32'h80000018,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd208
) (
  input  logic        clk24,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic [3:0]  memory_write_sections,
  output logic [31:0] read_value,
  output logic        read_selected,
  output logic        tx,
  output logic        irq
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- address decode ----------------
  logic [29:0] w_word;
  logic        w_hit_data, w_hit_stat, w_hit_div, w_hit_any;
  logic        w_unused;

  assign w_word     = memory_address[31:2];
  assign w_hit_data = (w_word == BASE_ADDRESS[31:2]);
  assign w_hit_stat = (w_word == BASE_ADDRESS[31:2] + 30'd1);
  assign w_hit_div  = (w_word == BASE_ADDRESS[31:2] + 30'd2);
  assign w_hit_any  = w_hit_data | w_hit_stat | w_hit_div;
  assign w_unused   = &{1'b0, memory_address[1:0], memory_write_value[31:16],
                        memory_write_sections[3:2]};

  // ---------------- registers ----------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_irq_en;
  logic [15:0]   r_div;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [15:0]   r_divl, w_divl_nxt;
  logic          w_tx_nxt, w_pop;

  logic          r_tx, r_irq, r_read_sel;
  logic [31:0]   r_read_value, w_rd_data;

  // ---------------- FIFO control ----------------
  logic        w_full, w_empty, w_busy;
  logic        w_push_req, w_push_ok, w_drop, w_stat_wr;
  logic [15:0] w_div_eff;
  logic        w_baud_end;
  logic [8:0]  w_cnt9;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = w_hit_data & memory_write_sections[0];
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push_ok;
  assign w_stat_wr  = w_hit_stat & memory_write_sections[0];
  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_baud_end = (r_baud == r_divl - 16'd1);
  assign w_cnt9     = 9'(r_count);

  // Storage has no reset: emptiness is tracked by r_count alone.
  always_ff @(posedge clk24) begin
    if (!reset && w_push_ok) r_mem[r_wr_ptr] <= memory_write_value[7:0];
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= DEFAULT_DIVISOR;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
      else if (w_stat_wr && memory_write_value[3]) r_ovf <= 1'b0;
      if (w_stat_wr) r_irq_en <= memory_write_value[4];
      if (w_hit_div && memory_write_sections[0]) r_div[7:0]  <= memory_write_value[7:0];
      if (w_hit_div && memory_write_sections[1]) r_div[15:8] <= memory_write_value[15:8];
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk24) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_divl  <= 16'd1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_divl  <= w_divl_nxt;
    end
  end

  // w_tx_nxt follows the current state; registering it puts the line one
  // cycle behind the FSM, so the start bit appears two cycles after a push.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_divl_nxt  = r_divl;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_divl_nxt  = w_div_eff;   // divisor frozen for the whole frame
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- read path and outputs ----------------
  always_comb begin
    w_rd_data = '0;
    if (w_hit_stat)
      w_rd_data = {16'd0, w_cnt9[7:0], 3'd0, r_irq_en, r_ovf, w_busy, w_empty, w_full};
    else if (w_hit_div)
      w_rd_data = {16'd0, r_div};
  end

  always_ff @(posedge clk24) begin
    if (reset) begin
      r_read_value <= '0;
      r_read_sel   <= 1'b0;
      r_tx         <= 1'b1;
      r_irq        <= 1'b0;
    end else begin
      r_read_value <= w_rd_data;
      r_read_sel   <= w_hit_any;
      r_tx         <= w_tx_nxt;
      r_irq        <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign read_value    = r_read_value;
  assign read_selected = r_read_sel;
  assign tx            = r_tx;
  assign irq           = r_irq;

endmodule
